// File: rtl/div_iter_pkg.sv
// rtl/div_iter_pkg.sv - shared state encodings and result field offsets for the iterative divider
package div_iter_pkg;

    typedef enum logic [1:0] {
        DIV_STATE_FREE    = 2'b00,
        DIV_STATE_DIVZERO = 2'b01,
        DIV_STATE_ON      = 2'b10,
        DIV_STATE_END     = 2'b11
    } div_state_e;

    // result is {hi = remainder, lo = quotient}
    localparam int DIV_LO_LSB = 0;

    function automatic int div_hi_lsb(input int width);
        return width;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - combinational slice of STEP chained restoring subtract-shift iterations
module div_step
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [STEP-1:0]  dividend_bits_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [STEP-1:0]  quot_o
);

    // Dividend bits are consumed MSB first; stage g produces quotient bit STEP-1-g.
    for (genvar g = 0; g < STEP; g++) begin : g_stage
        logic [WIDTH-1:0] rem_in;
        logic [WIDTH:0]   shifted;
        logic [WIDTH:0]   diff;
        logic [WIDTH-1:0] rem_out;

        if (g == 0) begin : g_first
            assign rem_in = rem_i;
        end else begin : g_chain
            assign rem_in = g_stage[g-1].rem_out;
        end

        assign shifted           = {rem_in, dividend_bits_i[STEP-1-g]};
        assign diff              = shifted - {1'b0, divisor_i};
        assign quot_o[STEP-1-g]  = ~diff[WIDTH];
        assign rem_out           = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end

    assign rem_o = g_stage[STEP-1].rem_out;

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - multi-cycle signed/unsigned iterative divider with annul and divide-by-zero fast path
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int HI_LSB = div_hi_lsb(WIDTH);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dq_q, dq_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               neg_quot_q, neg_quot_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]      step_rem;
    logic [STEP-1:0]       step_quot;
    logic [WIDTH+STEP-1:0] dq_shift;
    logic [WIDTH-1:0]      dq_next;
    logic [CNT_W-1:0]      cnt_next;
    logic [WIDTH-1:0]      a_mag;
    logic [WIDTH-1:0]      b_mag;

    // dq_q holds the remaining dividend bits at the top and collects quotient bits at the bottom.
    div_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_div_step (
        .rem_i           (rem_q),
        .dividend_bits_i (dq_q[WIDTH-1 -: STEP]),
        .divisor_i       (divisor_q),
        .rem_o           (step_rem),
        .quot_o          (step_quot)
    );

    assign dq_shift = {dq_q, step_quot};
    assign dq_next  = dq_shift[WIDTH-1:0];
    assign cnt_next = cnt_q + CNT_W'(STEP);
    assign a_mag    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign b_mag    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dq_d       = dq_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;

        unique case (state_q)
            DIV_STATE_FREE: begin
                result_d = '0;
                if (start_i && !annul_i) begin
                    dq_d       = a_mag;
                    divisor_d  = b_mag;
                    rem_d      = '0;
                    cnt_d      = '0;
                    neg_quot_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_rem_d  = signed_div_i && opdata1_i[WIDTH-1];
                    state_d    = (opdata2_i == '0) ? DIV_STATE_DIVZERO : DIV_STATE_ON;
                end
            end
            DIV_STATE_DIVZERO: begin
                result_d = '0;
                state_d  = annul_i ? DIV_STATE_FREE : DIV_STATE_END;
            end
            DIV_STATE_ON: begin
                if (annul_i) begin
                    result_d = '0;
                    cnt_d    = '0;
                    state_d  = DIV_STATE_FREE;
                end else begin
                    dq_d  = dq_next;
                    rem_d = step_rem;
                    cnt_d = cnt_next;
                    if (cnt_next == CNT_W'(WIDTH)) begin
                        result_d[DIV_LO_LSB +: WIDTH] = neg_quot_q ? -dq_next : dq_next;
                        result_d[HI_LSB +: WIDTH]     = neg_rem_q ? -step_rem : step_rem;
                        state_d                       = DIV_STATE_END;
                    end
                end
            end
            DIV_STATE_END: begin
                if (annul_i || !start_i) begin
                    result_d = '0;
                    state_d  = DIV_STATE_FREE;
                end
            end
            default: begin
                result_d = '0;
                state_d  = DIV_STATE_FREE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_STATE_FREE;
            cnt_q      <= '0;
            dq_q       <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dq_q       <= dq_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = (state_q == DIV_STATE_END);
    assign busy_o   = (state_q == DIV_STATE_ON) || (state_q == DIV_STATE_DIVZERO);

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - table-driven bench for div_iter, STEP=1 and STEP=4 instances driven in parallel
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic        annul;
    logic        sgn;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [63:0] result1, result4;
    logic        ready1, ready4;
    logic        busy1, busy4;

    int n_total;
    int n_pass;

    div_iter #(.WIDTH(32), .STEP(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .annul_i      (annul),
        .signed_div_i (sgn),
        .opdata1_i    (op_a),
        .opdata2_i    (op_b),
        .result_o     (result1),
        .ready_o      (ready1),
        .busy_o       (busy1)
    );

    div_iter #(.WIDTH(32), .STEP(4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .annul_i      (annul),
        .signed_div_i (sgn),
        .opdata1_i    (op_a),
        .opdata2_i    (op_b),
        .result_o     (result4),
        .ready_o      (ready4),
        .busy_o       (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat1;
        int          lat4;
        int          hold;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one division into both instances, wait for both ready, hold, then release.
    task automatic run_vec(input string name, input vec_t v);
        bit rdy1, rdy4;
        int c1, c4, b1, b4;
        rdy1 = 0; rdy4 = 0; c1 = 0; c4 = 0; b1 = 0; b4 = 0;
        sgn   = v.sgn;
        op_a  = v.a;
        op_b  = v.b;
        start = 1'b1;
        for (int cyc = 1; cyc <= 60 && !(rdy1 && rdy4); cyc++) begin
            tick();
            if (!rdy1) begin
                if (ready1) begin rdy1 = 1; c1 = cyc; end
                else if (busy1) b1++;
            end
            if (!rdy4) begin
                if (ready4) begin rdy4 = 1; c4 = cyc; end
                else if (busy4) b4++;
            end
        end
        op_a = 32'hDEAD_BEEF;
        op_b = 32'h0000_0000;
        sgn  = ~v.sgn;
        chk({name, " s1 ready-seen"}, 64'(rdy1), 64'd1);
        chk({name, " s4 ready-seen"}, 64'(rdy4), 64'd1);
        chk({name, " s1 latency"}, 64'(c1), 64'(v.lat1));
        chk({name, " s4 latency"}, 64'(c4), 64'(v.lat4));
        chk({name, " s1 busy-cycles"}, 64'(b1), 64'(v.lat1 - 1));
        chk({name, " s4 busy-cycles"}, 64'(b4), 64'(v.lat4 - 1));
        chk({name, " s1 result"}, result1, {v.r, v.q});
        chk({name, " s4 result"}, result4, {v.r, v.q});
        for (int h = 0; h < v.hold; h++) begin
            tick();
            chk({name, " s1 hold"}, {ready1, result1}, {1'b1, v.r, v.q});
            chk({name, " s4 hold"}, {ready4, result4}, {1'b1, v.r, v.q});
        end
        start = 1'b0;
        tick();
        chk({name, " s1 release"}, {62'd0, ready1, busy1}, 64'd0);
        chk({name, " s4 release"}, {62'd0, ready4, busy4}, 64'd0);
        chk({name, " s1 release result"}, result1, 64'd0);
        chk({name, " s4 release result"}, result4, 64'd0);
    endtask

    vec_t vecs[9];
    vec_t v;
    bit   seen_ready;

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst   = 1'b1;
        start = 1'b0;
        annul = 1'b0;
        sgn   = 1'b0;
        op_a  = '0;
        op_b  = '0;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33, 9, 0};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33, 9, 0};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33, 9, 0};
        vecs[3] = '{1'b0, 32'd5,          32'd0,          32'd0,          32'd0,          2,  2, 0};
        vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33, 9, 5};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0FFF_FFFF,  32'h0000_000F, 33, 9, 0};
        vecs[6] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33, 9, 0};
        vecs[7] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33, 9, 0};
        vecs[8] = '{1'b0, 32'd12345678,   32'd1000,       32'h0000_3039,  32'h0000_02A6,  33, 9, 2};

        repeat (3) tick();
        chk("reset s1", {result1, ready1, busy1}, 66'd0);
        chk("reset s4", {result4, ready4, busy4}, 66'd0);
        rst = 1'b0;
        tick();
        chk("idle s1", {result1, ready1, busy1}, 66'd0);

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Annul mid-operation, then an immediate new request.
        seen_ready = 0;
        sgn   = 1'b0;
        op_a  = 32'd1000;
        op_b  = 32'd3;
        start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            if (ready1) seen_ready = 1;
        end
        annul = 1'b1;
        tick();
        if (ready1) seen_ready = 1;
        annul = 1'b0;
        chk("annul s1 never ready", 64'(seen_ready), 64'd0);
        chk("annul s1 free", {result1, ready1, busy1}, 66'd0);
        chk("annul s4 free", {result4, ready4, busy4}, 66'd0);
        v = '{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 9, 0};
        run_vec("after-annul", v);

        // Reset pulse while both instances are iterating.
        sgn   = 1'b0;
        op_a  = 32'd1000;
        op_b  = 32'd3;
        start = 1'b1;
        repeat (4) tick();
        chk("pre-rst s1 busy", 64'(busy1), 64'd1);
        chk("pre-rst s4 busy", 64'(busy4), 64'd1);
        rst = 1'b1;
        tick();
        chk("rst s1", {result1, ready1, busy1}, 66'd0);
        chk("rst s4", {result4, ready4, busy4}, 66'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        v = '{1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33, 9, 0};
        run_vec("after-rst", v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
